slip_frame_rx: RTL and testbench
================================

# slip_frame_rx

Parametrised SLIP frame receiver with an on-chip frame buffer. Consumes a decoded byte stream (valid/byte pulses from `uart_rx`), strips SLIP framing and escapes, stores the payload, and releases a complete frame to the host logic only after a good closing END. Frames that are malformed, too long, stalled or arrive while the buffer is occupied are dropped with an error code. It sits between `uart_rx` and the packet/command decoder.

## Interface
- `MAX_LEN`, 256: payload buffer depth in bytes, at least 2.
- `LEN_W`, 9: width of length and pointer fields; must satisfy 2^LEN_W > MAX_LEN.
- `TIMEOUT_CLKS`, 0: inter-byte timeout in clk cycles; 0 disables the timeout.
- `CHAR_END` / `CHAR_ESC` / `CHAR_ESC_END` / `CHAR_ESC_ESC`, 8'hC0 / 8'hDB / 8'hDC / 8'hDD: framing characters.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_byte_valid`  in  1  one-cycle strobe; `i_byte` is valid.
- `i_byte`  in  8  received UART byte.
- `i_rd_en`  in  1  read request for the next buffered payload byte.
- `o_frame_ready`  out  1  a committed frame is held in the buffer.
- `o_frame_len`  out  LEN_W  payload length of the held frame, 1..MAX_LEN.
- `o_rd_valid`  out  1  one-cycle strobe; `o_rd_byte` is valid.
- `o_rd_byte`  out  8  payload byte.
- `o_rd_last`  out  1  qualifies `o_rd_valid`: this is the final byte of the frame.
- `o_err`  out  1  one-cycle error strobe.
- `o_err_code`  out  2  error code, valid with `o_err`: 0 bad escape, 1 too long, 2 overrun, 3 timeout.
- `o_drop_cnt`  out  8  count of dropped frames; saturates at 255.

## Operation
- States: IDLE, ACTIVE, ESCAPED, DISCARD. Reset enters IDLE.
- The write length counter `wlen` is cleared on every entry to ACTIVE from IDLE or DISCARD.
- **IDLE**
  - END -> ACTIVE.
  - Any other byte is ignored.
- **ACTIVE**
  - END with `wlen`=0 -> stay in ACTIVE. No commit, no error; a shared delimiter or empty frame.
  - END with `wlen`>0 -> commit (`o_frame_ready`<=1, `o_frame_len`<=`wlen`), `wlen`<=0, stay in ACTIVE. A single END both closes one frame and opens the next.
  - ESC -> ESCAPED.
  - Any other byte -> payload byte `i_byte`.
- **ESCAPED**
  - ESC_END -> payload byte `CHAR_END`, then ACTIVE.
  - ESC_ESC -> payload byte `CHAR_ESC`, then ACTIVE.
  - Any other byte -> error 0, DISCARD.
- **Payload write**, checked in this order:
  - If `o_frame_ready`=1 -> error 2 (overrun), DISCARD.
  - Else if `wlen`=MAX_LEN -> error 1 (too long), DISCARD.
  - Else write `buf[wlen]`, `wlen`++.
- **DISCARD**
  - Ignore all bytes until END, then ACTIVE with `wlen`=0.
  - END itself is not a commit.
- **Error side effects:** every error pulses `o_err`, sets `o_err_code`, and increments `o_drop_cnt` (saturating).
- **Timeout** (only when TIMEOUT_CLKS>0)
  - An idle counter counts cycles without `i_byte_valid` while in ESCAPED, or in ACTIVE with `wlen`>0. Any valid byte clears it.
  - On reaching TIMEOUT_CLKS: error 3, `wlen`<=0, -> IDLE.
  - Does not run in IDLE, DISCARD, or in ACTIVE with `wlen`=0.
- **Read side**
  - `i_rd_en` is honoured only while `o_frame_ready`=1; it is ignored otherwise.
  - Each honoured read returns `buf[rptr]` and increments `rptr`.
  - A read with `rptr`=`o_frame_len`-1 sets `o_rd_last` and, at the same edge, clears `o_frame_ready` and resets `rptr` to 0.
- **Reset mid-operation:** drops any partial or held frame; see Timing for reset values.

## Timing
- All outputs are registered.
- Reset values: `o_frame_ready`=0, `o_frame_len`=0, `o_rd_valid`=0, `o_rd_byte`=0, `o_rd_last`=0, `o_err`=0, `o_err_code`=0, `o_drop_cnt`=0. Internal `wlen`=0, `rptr`=0.
- Commit: `o_frame_ready` rises in cycle N+1 for an END strobed in cycle N.
- Errors: `o_err` pulses in cycle N+1 for the offending byte in cycle N. A timeout pulses in the cycle after the count is reached.
- Reads: `i_rd_en` in cycle N gives `o_rd_valid`/`o_rd_byte`/`o_rd_last` in cycle N+1. Back-to-back reads every cycle are supported. `o_frame_ready` is low in cycle N+1 after the last read.
- Simultaneous last-byte read and incoming payload byte in the same cycle: the overrun check uses the pre-edge `o_frame_ready`=1, so the frame is dropped with error 2.
- Simultaneous last-byte read and incoming END in the same cycle: the commit is legal. `o_frame_ready` stays 1 with the new length.
- `o_err`, `o_rd_valid` and `o_rd_last` are single-cycle pulses. `o_err_code` holds its value until the next error.
- The input may strobe every cycle; no backpressure exists toward `uart_rx`.

## Test plan
- Stream C0 01 DB DC DB DD 02 C0 -> `o_frame_ready`=1, `o_frame_len`=4. Four `i_rd_en` cycles -> bytes 01 C0 DB 02, with `o_rd_last` on 02. Then `o_frame_ready`=0.
- C0 C0 C0 AA C0 BB C0 with a single read drain between frames -> two frames (AA, then BB), each of length 1. No error for the empty frames.
- C0 11 DB 55 22 C0 33 C0 -> error 0. The 22 and closing C0 are discarded. Next frame {33} is committed, len 1. `o_drop_cnt`=1.
- MAX_LEN=4: C0 then 5 payload bytes then C0 -> error 1 on the 5th byte, no commit. `o_drop_cnt`=1.
- Held frame unread, then C0 77 C0 -> error 2 on 77. The original frame is still readable intact.
- TIMEOUT_CLKS=100: C0 12 then 100 idle cycles -> error 3, state IDLE. A following 34 C0 commits nothing. A reset asserted mid-frame clears all outputs to reset values.

Source files
------------

// File: rtl/slip_frame_rx.sv
// SLIP frame receiver: strips framing/escapes into a frame buffer and
// releases a frame to the host only after a good closing END.
module slip_frame_rx #(
    parameter int         MAX_LEN      = 256,
    parameter int         LEN_W        = 9,
    parameter int         TIMEOUT_CLKS = 0,
    parameter logic [7:0] CHAR_END     = 8'hC0,
    parameter logic [7:0] CHAR_ESC     = 8'hDB,
    parameter logic [7:0] CHAR_ESC_END = 8'hDC,
    parameter logic [7:0] CHAR_ESC_ESC = 8'hDD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte,
    input  logic             i_rd_en,
    output logic             o_frame_ready,
    output logic [LEN_W-1:0] o_frame_len,
    output logic             o_rd_valid,
    output logic [7:0]       o_rd_byte,
    output logic             o_rd_last,
    output logic             o_err,
    output logic [1:0]       o_err_code,
    output logic [7:0]       o_drop_cnt
);

    localparam int              AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] L_MAX = LEN_W'(MAX_LEN);
    localparam logic [31:0]     L_TO  = 32'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_ESCAPED,
        S_DISCARD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_wlen;
    logic [LEN_W-1:0] r_rptr;
    logic [31:0]      r_idle_cnt;
    logic [7:0]       r_buf [MAX_LEN];

    logic             w_is_end;
    logic             w_is_esc;
    logic             w_pay_fail;
    logic             w_pay_req;
    logic [7:0]       w_pay_byte;
    logic             w_write;
    logic             w_commit;
    logic             w_wlen_clr;
    logic             w_err;
    logic [1:0]       w_err_code;
    logic             w_tmr_run;
    logic             w_timeout;
    logic             w_rd;
    logic             w_rd_last;

    assign w_is_end   = (i_byte == CHAR_END);
    assign w_is_esc   = (i_byte == CHAR_ESC);
    assign w_pay_fail = o_frame_ready || (r_wlen == L_MAX);

    // Timer only guards a frame that has actually started carrying data
    assign w_tmr_run = (TIMEOUT_CLKS > 0) &&
                       ((r_state == S_ESCAPED) ||
                        ((r_state == S_ACTIVE) && (r_wlen != '0)));
    assign w_timeout = w_tmr_run && !i_byte_valid &&
                       (r_idle_cnt == L_TO - 32'd1);

    assign w_rd      = i_rd_en && o_frame_ready;
    assign w_rd_last = (r_rptr == o_frame_len - LEN_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_byte_valid && w_is_end) w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else if (i_byte_valid) begin
                    if (w_is_esc)                   w_state_nxt = S_ESCAPED;
                    else if (!w_is_end && w_pay_fail) w_state_nxt = S_DISCARD;
                end
            end
            S_ESCAPED: begin
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else if (i_byte_valid) begin
                    if ((i_byte == CHAR_ESC_END) || (i_byte == CHAR_ESC_ESC))
                        w_state_nxt = w_pay_fail ? S_DISCARD : S_ACTIVE;
                    else
                        w_state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (i_byte_valid && w_is_end) w_state_nxt = S_ACTIVE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Action decode: payload writes, commits and error reporting
    always_comb begin
        w_pay_req  = 1'b0;
        w_pay_byte = i_byte;
        w_write    = 1'b0;
        w_commit   = 1'b0;
        w_wlen_clr = 1'b0;
        w_err      = 1'b0;
        w_err_code = 2'd0;
        unique case (r_state)
            S_IDLE, S_DISCARD: begin
                if (i_byte_valid && w_is_end) w_wlen_clr = 1'b1;
            end
            S_ACTIVE: begin
                if (i_byte_valid) begin
                    if (w_is_end) w_commit = (r_wlen != '0);
                    else if (!w_is_esc) w_pay_req = 1'b1;
                end
            end
            S_ESCAPED: begin
                if (i_byte_valid) begin
                    if (i_byte == CHAR_ESC_END) begin
                        w_pay_req  = 1'b1;
                        w_pay_byte = CHAR_END;
                    end else if (i_byte == CHAR_ESC_ESC) begin
                        w_pay_req  = 1'b1;
                        w_pay_byte = CHAR_ESC;
                    end else begin
                        w_err      = 1'b1;
                        w_err_code = 2'd0;
                    end
                end
            end
            default: ;
        endcase
        // Overrun wins over length so a held frame is never disturbed
        if (w_pay_req) begin
            if (o_frame_ready) begin
                w_err      = 1'b1;
                w_err_code = 2'd2;
            end else if (r_wlen == L_MAX) begin
                w_err      = 1'b1;
                w_err_code = 2'd1;
            end else begin
                w_write = 1'b1;
            end
        end
        if (w_timeout) begin
            w_err      = 1'b1;
            w_err_code = 2'd3;
            w_wlen_clr = 1'b1;
        end
    end

    // Inter-byte idle counter
    always_ff @(posedge clk) begin
        if (reset || !w_tmr_run || i_byte_valid || w_timeout)
            r_idle_cnt <= '0;
        else
            r_idle_cnt <= r_idle_cnt + 32'd1;
    end

    // Write length tracking
    always_ff @(posedge clk) begin
        if (reset || w_commit || w_wlen_clr) r_wlen <= '0;
        else if (w_write)                    r_wlen <= r_wlen + LEN_W'(1);
    end

    // Frame buffer storage
    always_ff @(posedge clk) begin
        if (w_write) r_buf[r_wlen[AW-1:0]] <= w_pay_byte;
    end

    // Read port and held-frame status; a commit overrides a final read
    always_ff @(posedge clk) begin
        if (reset) begin
            o_frame_ready <= 1'b0;
            o_frame_len   <= '0;
            o_rd_valid    <= 1'b0;
            o_rd_byte     <= 8'd0;
            o_rd_last     <= 1'b0;
            r_rptr        <= '0;
        end else begin
            o_rd_valid <= w_rd;
            o_rd_last  <= w_rd && w_rd_last;
            if (w_rd) begin
                o_rd_byte <= r_buf[r_rptr[AW-1:0]];
                r_rptr    <= w_rd_last ? '0 : r_rptr + LEN_W'(1);
            end
            if (w_commit) begin
                o_frame_ready <= 1'b1;
                o_frame_len   <= r_wlen;
            end else if (w_rd && w_rd_last) begin
                o_frame_ready <= 1'b0;
            end
        end
    end

    // Error strobe, sticky code and saturating drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            o_err      <= 1'b0;
            o_err_code <= 2'd0;
            o_drop_cnt <= 8'd0;
        end else begin
            o_err <= w_err;
            if (w_err) begin
                o_err_code <= w_err_code;
                if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_slip_frame_rx.sv
// Directed bench for slip_frame_rx (MAX_LEN=4, timeout 100 clocks).
module tb_slip_frame_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_byte_valid = 1'b0;
    logic [7:0] i_byte = 8'd0;
    logic       i_rd_en = 1'b0;
    logic       o_frame_ready;
    logic [2:0] o_frame_len;
    logic       o_rd_valid;
    logic [7:0] o_rd_byte;
    logic       o_rd_last;
    logic       o_err;
    logic [1:0] o_err_code;
    logic [7:0] o_drop_cnt;

    int vec  = 0;
    int miss = 0;
    int err_cnt = 0;
    logic [1:0] err_last = 2'd0;

    slip_frame_rx #(
        .MAX_LEN(4),
        .LEN_W(3),
        .TIMEOUT_CLKS(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_byte_valid(i_byte_valid),
        .i_byte(i_byte),
        .i_rd_en(i_rd_en),
        .o_frame_ready(o_frame_ready),
        .o_frame_len(o_frame_len),
        .o_rd_valid(o_rd_valid),
        .o_rd_byte(o_rd_byte),
        .o_rd_last(o_rd_last),
        .o_err(o_err),
        .o_err_code(o_err_code),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    // Error pulse monitor: counts high cycles of o_err
    always @(negedge clk) begin
        if (o_err === 1'b1) begin
            err_cnt++;
            err_last = o_err_code;
        end
    end

    task automatic send(input logic [7:0] b);
        i_byte = b;
        i_byte_valid = 1'b1;
        @(posedge clk);
        #1 i_byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_byte_valid = 1'b0;
        i_rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vec++;
        if ({o_frame_ready, o_frame_len, o_rd_valid, o_rd_last, o_err} !== 7'd0) begin
            miss++;
            $display("FAIL reset_flags: got %b want 0",
                     {o_frame_ready, o_frame_len, o_rd_valid, o_rd_last, o_err});
        end
        vec++;
        if ({o_rd_byte, o_err_code, o_drop_cnt} !== 18'd0) begin
            miss++;
            $display("FAIL reset_data: got %h want 0", {o_rd_byte, o_err_code, o_drop_cnt});
        end
    endtask

    task automatic test_escape_frame();
        logic [7:0] s [8] = '{8'hC0, 8'h01, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'h02, 8'hC0};
        logic [7:0] e [4] = '{8'h01, 8'hC0, 8'hDB, 8'h02};
        int e0;
        do_reset();
        e0 = err_cnt;
        foreach (s[k]) send(s[k]);
        vec++;
        if (o_frame_ready !== 1'b1 || o_frame_len !== 3'd4) begin
            miss++;
            $display("FAIL esc_commit: got rdy=%b len=%0d want rdy=1 len=4",
                     o_frame_ready, o_frame_len);
        end
        i_rd_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) i_rd_en = 1'b0;
            vec++;
            if (o_rd_valid !== 1'b1 || o_rd_byte !== e[k] || o_rd_last !== (k == 3)) begin
                miss++;
                $display("FAIL esc_read%0d: got v=%b b=%h l=%b want v=1 b=%h l=%b",
                         k, o_rd_valid, o_rd_byte, o_rd_last, e[k], (k == 3));
            end
        end
        vec++;
        if (o_frame_ready !== 1'b0) begin
            miss++;
            $display("FAIL esc_drained: got rdy=%b want 0", o_frame_ready);
        end
        idle(1);
        vec++;
        if (o_rd_valid !== 1'b0 || err_cnt !== e0) begin
            miss++;
            $display("FAIL esc_quiet: got v=%b errs=%0d want v=0 errs=%0d",
                     o_rd_valid, err_cnt - e0, 0);
        end
    endtask

    task automatic test_back_to_back();
        int e0;
        do_reset();
        e0 = err_cnt;
        send(8'hC0); send(8'hC0); send(8'hC0); send(8'hAA); send(8'hC0);
        vec++;
        if (o_frame_ready !== 1'b1 || o_frame_len !== 3'd1) begin
            miss++;
            $display("FAIL b2b_first: got rdy=%b len=%0d want rdy=1 len=1",
                     o_frame_ready, o_frame_len);
        end
        i_rd_en = 1'b1;
        idle(1);
        i_rd_en = 1'b0;
        vec++;
        if (o_rd_byte !== 8'hAA || o_rd_last !== 1'b1 || o_frame_ready !== 1'b0) begin
            miss++;
            $display("FAIL b2b_read1: got b=%h l=%b rdy=%b want b=aa l=1 rdy=0",
                     o_rd_byte, o_rd_last, o_frame_ready);
        end
        send(8'hBB); send(8'hC0);
        vec++;
        if (o_frame_ready !== 1'b1 || o_frame_len !== 3'd1) begin
            miss++;
            $display("FAIL b2b_second: got rdy=%b len=%0d want rdy=1 len=1",
                     o_frame_ready, o_frame_len);
        end
        i_rd_en = 1'b1;
        idle(1);
        i_rd_en = 1'b0;
        vec++;
        if (o_rd_byte !== 8'hBB || o_rd_last !== 1'b1) begin
            miss++;
            $display("FAIL b2b_read2: got b=%h l=%b want b=bb l=1", o_rd_byte, o_rd_last);
        end
        idle(1);
        vec++;
        if (err_cnt !== e0 || o_drop_cnt !== 8'd0) begin
            miss++;
            $display("FAIL b2b_noerr: got errs=%0d drops=%0d want 0 0",
                     err_cnt - e0, o_drop_cnt);
        end
    endtask

    task automatic test_bad_escape();
        logic [7:0] s [8] = '{8'hC0, 8'h11, 8'hDB, 8'h55, 8'h22, 8'hC0, 8'h33, 8'hC0};
        int e0;
        do_reset();
        e0 = err_cnt;
        foreach (s[k]) send(s[k]);
        idle(1);
        vec++;
        if (err_cnt !== e0 + 1 || err_last !== 2'd0 || o_drop_cnt !== 8'd1) begin
            miss++;
            $display("FAIL badesc_err: got errs=%0d code=%0d drops=%0d want 1 0 1",
                     err_cnt - e0, err_last, o_drop_cnt);
        end
        vec++;
        if (o_frame_ready !== 1'b1 || o_frame_len !== 3'd1) begin
            miss++;
            $display("FAIL badesc_next: got rdy=%b len=%0d want rdy=1 len=1",
                     o_frame_ready, o_frame_len);
        end
        i_rd_en = 1'b1;
        idle(1);
        i_rd_en = 1'b0;
        vec++;
        if (o_rd_byte !== 8'h33 || o_rd_last !== 1'b1) begin
            miss++;
            $display("FAIL badesc_read: got b=%h l=%b want b=33 l=1", o_rd_byte, o_rd_last);
        end
    endtask

    task automatic test_too_long();
        logic [7:0] s [7] = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hC0};
        int e0;
        do_reset();
        e0 = err_cnt;
        foreach (s[k]) send(s[k]);
        idle(1);
        vec++;
        if (err_cnt !== e0 + 1 || err_last !== 2'd1 || o_err_code !== 2'd1) begin
            miss++;
            $display("FAIL toolong_err: got errs=%0d code=%0d want 1 1",
                     err_cnt - e0, err_last);
        end
        vec++;
        if (o_frame_ready !== 1'b0 || o_drop_cnt !== 8'd1) begin
            miss++;
            $display("FAIL toolong_drop: got rdy=%b drops=%0d want rdy=0 drops=1",
                     o_frame_ready, o_drop_cnt);
        end
    endtask

    task automatic test_overrun();
        int e0;
        do_reset();
        e0 = err_cnt;
        send(8'hC0); send(8'hA1); send(8'hA2); send(8'hC0);
        send(8'hC0); send(8'h77); send(8'hC0);
        idle(1);
        vec++;
        if (err_cnt !== e0 + 1 || err_last !== 2'd2 || o_drop_cnt !== 8'd1) begin
            miss++;
            $display("FAIL overrun_err: got errs=%0d code=%0d drops=%0d want 1 2 1",
                     err_cnt - e0, err_last, o_drop_cnt);
        end
        vec++;
        if (o_frame_ready !== 1'b1 || o_frame_len !== 3'd2) begin
            miss++;
            $display("FAIL overrun_held: got rdy=%b len=%0d want rdy=1 len=2",
                     o_frame_ready, o_frame_len);
        end
        i_rd_en = 1'b1;
        idle(1);
        vec++;
        if (o_rd_byte !== 8'hA1 || o_rd_last !== 1'b0) begin
            miss++;
            $display("FAIL overrun_rd0: got b=%h l=%b want b=a1 l=0", o_rd_byte, o_rd_last);
        end
        idle(1);
        i_rd_en = 1'b0;
        vec++;
        if (o_rd_byte !== 8'hA2 || o_rd_last !== 1'b1 || o_frame_ready !== 1'b0) begin
            miss++;
            $display("FAIL overrun_rd1: got b=%h l=%b rdy=%b want b=a2 l=1 rdy=0",
                     o_rd_byte, o_rd_last, o_frame_ready);
        end
    endtask

    task automatic test_timeout();
        int e0;
        int n;
        do_reset();
        e0 = err_cnt;
        send(8'hC0); send(8'h12);
        n = 0;
        for (int k = 1; k <= 150; k++) begin
            @(posedge clk);
            #1;
            if (o_err === 1'b1) begin
                n = k;
                break;
            end
        end
        vec++;
        if (n < 100 || n > 101 || o_err_code !== 2'd3) begin
            miss++;
            $display("FAIL timeout_fire: got cycles=%0d code=%0d want 100..101 code=3",
                     n, o_err_code);
        end
        idle(2);
        send(8'h34); send(8'hC0);
        idle(2);
        vec++;
        if (o_frame_ready !== 1'b0 || err_cnt !== e0 + 1 || o_drop_cnt !== 8'd1) begin
            miss++;
            $display("FAIL timeout_idle: got rdy=%b errs=%0d drops=%0d want 0 1 1",
                     o_frame_ready, err_cnt - e0, o_drop_cnt);
        end
        send(8'hC0);
        idle(120);
        vec++;
        if (err_cnt !== e0 + 1) begin
            miss++;
            $display("FAIL timeout_empty: got errs=%0d want 1", err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'hC0); send(8'h57); send(8'hC0);
        send(8'h58); send(8'h59);
        idle(1);
        vec++;
        if (o_frame_ready !== 1'b1 || o_err_code !== 2'd2 || o_drop_cnt !== 8'd1) begin
            miss++;
            $display("FAIL midrst_pre: got rdy=%b code=%0d drops=%0d want 1 2 1",
                     o_frame_ready, o_err_code, o_drop_cnt);
        end
        do_reset();
        vec++;
        if ({o_frame_ready, o_frame_len, o_rd_valid, o_rd_last, o_err,
             o_rd_byte, o_err_code, o_drop_cnt} !== 25'd0) begin
            miss++;
            $display("FAIL midrst_clear: got %h want 0",
                     {o_frame_ready, o_frame_len, o_rd_valid, o_rd_last, o_err,
                      o_rd_byte, o_err_code, o_drop_cnt});
        end
        send(8'h60); send(8'hC0);
        idle(1);
        vec++;
        if (o_frame_ready !== 1'b0) begin
            miss++;
            $display("FAIL midrst_idle: got rdy=%b want 0", o_frame_ready);
        end
    endtask

    initial begin
        test_reset();
        test_escape_frame();
        test_back_to_back();
        test_bad_escape();
        test_too_long();
        test_overrun();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
